// File: rtl/regfile_pkg.sv
// Shared encodings, default geometry and named register indices for regfile_mp.
package regfile_pkg;

  // RAM pointer operation encodings
  typedef enum logic [1:0] {
    PTR_HOLD = 2'b00,
    PTR_INC  = 2'b01,
    PTR_DEC  = 2'b10,
    PTR_RSVD = 2'b11
  } ptr_op_e;

  // Default geometry
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_NUM_REGS   = 16;
  localparam int unsigned DEF_NUM_RD     = 2;
  localparam int unsigned DEF_RAM_ADDR_W = 12;
  localparam int unsigned DEF_RM_IDX     = 9;

  // Named register indices for the default map
  localparam int unsigned R0  = 0;
  localparam int unsigned R1  = 1;
  localparam int unsigned R2  = 2;
  localparam int unsigned R3  = 3;
  localparam int unsigned R4  = 4;
  localparam int unsigned R5  = 5;
  localparam int unsigned R6  = 6;
  localparam int unsigned R7  = 7;
  localparam int unsigned R8  = 8;
  localparam int unsigned RM0 = DEF_RM_IDX;
  localparam int unsigned RM1 = DEF_RM_IDX + 1;

endpackage

// File: rtl/regfile_mp_ram_ptr_unit.sv
// Next-value logic for the RAM pointer held in a register pair.
module ram_ptr_unit
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RAM_ADDR_W = DEF_RAM_ADDR_W
) (
  input  logic [RAM_ADDR_W-1:0] ptr_i,
  input  logic [1:0]            op_i,
  input  logic                  suppress_i,
  output logic [DATA_W-1:0]     next_lo_c_o,
  output logic [DATA_W-1:0]     next_hi_c_o,
  output logic                  upd_c_o
);

  localparam int unsigned HI_W = RAM_ADDR_W - DATA_W;

  logic [RAM_ADDR_W-1:0] next_ptr;

  // Modulo increment/decrement; an explicit write to the pair cancels the op
  always_comb begin
    next_ptr = ptr_i;
    upd_c_o  = 1'b0;
    if (!suppress_i) begin
      case (op_i)
        PTR_INC: begin
          next_ptr = ptr_i + RAM_ADDR_W'(1);
          upd_c_o  = 1'b1;
        end
        PTR_DEC: begin
          next_ptr = ptr_i - RAM_ADDR_W'(1);
          upd_c_o  = 1'b1;
        end
        default: begin
          next_ptr = ptr_i;
          upd_c_o  = 1'b0;
        end
      endcase
    end
  end

  // Split back into register form; high register bits above the pointer read as 0
  assign next_lo_c_o = next_ptr[DATA_W-1:0];
  assign next_hi_c_o = DATA_W'(next_ptr[RAM_ADDR_W-1:DATA_W]);

  if (HI_W == 0 || HI_W > DATA_W) begin : g_bad_w
    $error("ram_ptr_unit: RAM_ADDR_W must satisfy DATA_W < RAM_ADDR_W <= 2*DATA_W");
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD read ports with optional
// bypass, and a register-pair RAM pointer with post-increment/decrement.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter  int unsigned NUM_RD     = DEF_NUM_RD,
  parameter  int unsigned BYPASS     = 1,
  parameter  int unsigned RM_IDX     = DEF_RM_IDX,
  parameter  int unsigned RAM_ADDR_W = DEF_RAM_ADDR_W,
  localparam int unsigned AW         = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [NUM_RD*AW-1:0]     r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  input  logic [1:0]               ptr_op,
  output logic [RAM_ADDR_W-1:0]    ram_addr
);

  localparam int unsigned HI_W   = RAM_ADDR_W - DATA_W;
  localparam int unsigned RM_LO  = RM_IDX;
  localparam int unsigned RM_HI  = RM_IDX + 1;

  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  logic [RAM_ADDR_W-1:0] cur_ptr;
  logic                  ptr_suppress;
  logic                  ptr_upd;
  logic [DATA_W-1:0]     ptr_lo;
  logic [DATA_W-1:0]     ptr_hi;

  // True when an index addresses an implemented register
  function automatic logic in_range(input logic [AW-1:0] a);
    return (AW+1)'(a) < (AW+1)'(NUM_REGS);
  endfunction

  // Current pointer straight from storage; never bypassed
  assign cur_ptr  = {regs_q[RM_HI][HI_W-1:0], regs_q[RM_LO]};
  assign ram_addr = cur_ptr;

  // Any enabled write to the pointer pair wins over the pointer op
  assign ptr_suppress = (wa_en && (wa_addr == AW'(RM_LO) || wa_addr == AW'(RM_HI))) ||
                        (wb_en && (wb_addr == AW'(RM_LO) || wb_addr == AW'(RM_HI)));

  ram_ptr_unit #(
    .DATA_W     (DATA_W),
    .RAM_ADDR_W (RAM_ADDR_W)
  ) u_ptr (
    .ptr_i       (cur_ptr),
    .op_i        (ptr_op),
    .suppress_i  (ptr_suppress),
    .next_lo_c_o (ptr_lo),
    .next_hi_c_o (ptr_hi),
    .upd_c_o     (ptr_upd)
  );

  // Write decode: pointer update, then port B, then port A (A has priority)
  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (ptr_upd && k == RM_LO) regs_d[k] = ptr_lo;
      if (ptr_upd && k == RM_HI) regs_d[k] = ptr_hi;
      if (wb_en && wb_addr == AW'(k)) regs_d[k] = wb_data;
      if (wa_en && wa_addr == AW'(k)) regs_d[k] = wa_data;
    end
  end

  // Storage array with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  // Read ports with optional same-cycle write forwarding
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;

    assign ra = r_addr[i*AW +: AW];

    // Stored value, overridden by B then A when bypass is enabled; 0 in reset
    always_comb begin
      rd = '0;
      if (in_range(ra)) begin
        rd = regs_q[ra];
        if (BYPASS != 0) begin
          if (wb_en && wb_addr == ra) rd = wb_data;
          if (wa_en && wa_addr == ra) rd = wa_data;
        end
      end
      if (!rst) rd = '0;
    end

    assign r_data[i*DATA_W +: DATA_W] = rd;
  end

  if (NUM_RD == 0 || NUM_RD > 4) begin : g_bad_rd
    $error("regfile_mp: NUM_RD must be 1..4");
  end
  if (RM_IDX + 1 >= NUM_REGS) begin : g_bad_rm
    $error("regfile_mp: RM_IDX+1 must be below NUM_REGS");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath, successor to the fixed 11×8 single-write file. Two write ports: ALU writeback and load/immediate. A configurable number of combinational read ports, with optional write-to-read bypass. A hardware RAM pointer built from a register pair supports post-increment and post-decrement, so memory walks need no ALU cycles. Sits between decode/ALU and the RAM address mux.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- NUM_REGS, 16, number of registers; address width AW = clog2(NUM_REGS)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads show stored value only
- RM_IDX, 9, index of pointer low byte; RM_IDX+1 holds the high part (RM_IDX+1 < NUM_REGS)
- RAM_ADDR_W, 12, RAM pointer width (DATA_W < RAM_ADDR_W ≤ 2·DATA_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wa_en  in  1  write port A enable (ALU)
- wa_addr  in  AW  write port A register index
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B enable (load/immediate)
- wb_addr  in  AW  write port B register index
- wb_data  in  DATA_W  write port B data
- r_addr  in  NUM_RD·AW  packed read indices, port i at [i·AW +: AW]
- r_data  out  NUM_RD·DATA_W  packed read data, port i at [i·DATA_W +: DATA_W]
- ptr_op  in  2  00 hold, 01 post-increment, 10 post-decrement, 11 hold (reserved)
- ram_addr  out  RAM_ADDR_W  {reg[RM_IDX+1][RAM_ADDR_W-DATA_W-1:0], reg[RM_IDX]}

## Operation
- Reset (rst low, any time, mid-write included): all registers clear to 0 immediately; ram_addr = 0; r_data = 0 for every port.
- Write: on the rising edge, reg[wa_addr] ← wa_data if wa_en; reg[wb_addr] ← wb_data if wb_en.
- Both ports write the same index in one cycle: port A wins and B is dropped.
- Index ≥ NUM_REGS: the write is ignored and a read returns 0.
- Read: r_data[i] = reg[r_addr[i]], combinational.
- BYPASS=1: if an enabled write targets r_addr[i] in the same cycle, r_data[i] returns that write data, applying the A-over-B priority.
- BYPASS=0: reads return the pre-edge value.
- Pointer op: on the edge, the RAM_ADDR_W-bit pointer ← pointer ± 1 modulo 2^RAM_ADDR_W.
  - Wrap cases: 0xFFF+1 → 0x000; 0x000−1 → 0xFFF.
  - Bits of reg[RM_IDX+1] above RAM_ADDR_W-DATA_W are written 0 on any pointer op.
- Pointer op vs explicit write: any enabled write (A or B) to RM_IDX or RM_IDX+1 in the same cycle suppresses ptr_op entirely; the explicit write(s) land unchanged.
- The pointer op is not bypassed to read ports; reads of RM_IDX/RM_IDX+1 show the pre-edge value.
- ram_addr is derived from the stored registers only: no bypass, and no dependence on same-cycle writes.

## Timing
- Write latency: 1 cycle. A value written at edge N is visible on reads and ram_addr after edge N.
- With BYPASS=1 it is also visible in cycle N-1, the cycle the write is presented.
- Read latency: 0 (combinational from r_addr and storage).
- Pointer update: 1 cycle. ram_addr changes just after the edge that samples ptr_op.
- Back-to-back ptr_op=01 for k cycles advances ram_addr by k.
- No handshake; all enables are single-cycle qualifiers sampled at each edge.
- Asynchronous reset assertion clears state without a clock. Deassertion is assumed synchronised upstream.
- The first write is accepted on the first edge after rst goes high.

## Structure
- Shared package regfile_pkg:
  - PTR_HOLD/PTR_INC/PTR_DEC/PTR_RSVD encodings
  - default DATA_W, NUM_REGS, RAM_ADDR_W, RM_IDX
  - named register indices, including RM0 = RM_IDX and RM1 = RM_IDX+1
- Sub-module ram_ptr_unit:
  - inputs: current pointer, ptr_op, suppress flag
  - output: next pointer and an update-enable
  - handles wrap and upper-bit clearing
- Top level holds the storage array, write-priority/decode logic, bypass muxes (generate loop over NUM_RD) and ram_addr assembly.

## Test plan
- Reset: write 0xAA to r3, pull rst low between edges → r_data reads 0 and ram_addr = 0x000 immediately, without a clock edge.
- Dual-write collision: wa(r5,0x11), wb(r5,0x22) same edge → r5 = 0x11. In that cycle with BYPASS=1, r_data on r5 = 0x11.
- Bypass vs no bypass: write r7 = 0x3C while reading r7 → same cycle returns 0x3C (BYPASS=1) or old value 0x00 (BYPASS=0). Both read 0x3C next cycle.
- Pointer wrap: load RM0=0xFF, RM1=0x0F, then ptr_op=01 → ram_addr 0x000, RM1 = 0x00. Then ptr_op=10 → ram_addr 0xFFF.
- Pointer/write conflict: ram_addr=0x123, ptr_op=01 with wb writing RM0=0x50 → ram_addr = 0x150, with no increment applied.
- Out-of-range and multi-port: NUM_REGS=12, write index 13 → no register changes and a read of 13 = 0. Three read ports on r0/r1/r2 return independent values.
